// File: rtl/weight_load_sequencer_if.sv
// Stream-in / strobe-out bundle between the host configuration path and the
// weight load sequencer. The master side feeds words; the slave side is the sequencer.
interface weight_load_sequencer_if #(
   parameter int DATA_WIDTH = 32
);
   logic                  start;
   logic [DATA_WIDTH-1:0] s_data;
   logic                  s_valid;
   logic                  s_ready;
   logic [31:0]           config_layer_num;
   logic [31:0]           config_neuron_num;
   logic                  weightValid;
   logic [DATA_WIDTH-1:0] weightValue;
   logic                  biasValid;
   logic [DATA_WIDTH-1:0] biasValue;
   logic                  busy;
   logic                  done;

   modport master (
      output start, s_data, s_valid,
      input  s_ready, config_layer_num, config_neuron_num,
             weightValid, weightValue, biasValid, biasValue, busy, done
   );

   modport slave (
      input  start, s_data, s_valid,
      output s_ready, config_layer_num, config_neuron_num,
             weightValid, weightValue, biasValid, biasValue, busy, done
   );
endinterface

// File: rtl/weight_load_sequencer.sv
// Weight/bias preload sequencer for the 4-layer DNN datapath.
// Consumes one flat word stream (per layer, per neuron: NW weights then one bias)
// and emits registered weight/bias strobes with coherent layer/neuron tags.
module weight_load_sequencer #(
   parameter int DATA_WIDTH = 32,
   parameter int CNT_WIDTH  = 16,
   parameter int NN1 = 30,
   parameter int NN2 = 30,
   parameter int NN3 = 10,
   parameter int NN4 = 10,
   parameter int NW1 = 784,
   parameter int NW2 = 30,
   parameter int NW3 = 30,
   parameter int NW4 = 10
) (
   input logic                    clk,
   input logic                    rst,
   weight_load_sequencer_if.slave bus
);

   typedef enum logic [1:0] {
      IDLE,
      WEIGHT,
      BIAS,
      DONE
   } state_t;

   state_t state, state_next;

   logic [2:0]            layer, layer_next;
   logic [CNT_WIDTH-1:0]  neuron, neuron_next;
   logic [CNT_WIDTH-1:0]  wcnt, wcnt_next;
   logic [CNT_WIDTH-1:0]  nw_cur, nn_cur;

   logic                  ready, ready_next;
   logic                  busy, busy_next;
   logic                  done, done_next;
   logic                  wvalid, wvalid_next;
   logic                  bvalid, bvalid_next;
   logic [DATA_WIDTH-1:0] wvalue, wvalue_next;
   logic [DATA_WIDTH-1:0] bvalue, bvalue_next;
   logic [31:0]           layer_tag, layer_tag_next;
   logic [31:0]           neuron_tag, neuron_tag_next;

   logic                  beat;

   // A beat is a word accepted this cycle; ready is a flop, so no path from s_valid to s_ready.
   assign beat = bus.s_valid && ready;

   // Per-layer geometry lookup: weights per neuron and neuron count for the active layer.
   always_comb begin
      nw_cur = CNT_WIDTH'(NW1);
      nn_cur = CNT_WIDTH'(NN1);
      case (layer)
         3'd2: begin
            nw_cur = CNT_WIDTH'(NW2);
            nn_cur = CNT_WIDTH'(NN2);
         end
         3'd3: begin
            nw_cur = CNT_WIDTH'(NW3);
            nn_cur = CNT_WIDTH'(NN3);
         end
         3'd4: begin
            nw_cur = CNT_WIDTH'(NW4);
            nn_cur = CNT_WIDTH'(NN4);
         end
         default: begin
            nw_cur = CNT_WIDTH'(NW1);
            nn_cur = CNT_WIDTH'(NN1);
         end
      endcase
   end

   // Next-state, counter and output computation; everything is registered together below.
   always_comb begin
      state_next      = state;
      layer_next      = layer;
      neuron_next     = neuron;
      wcnt_next       = wcnt;
      busy_next       = busy;
      done_next       = 1'b0;
      wvalid_next     = 1'b0;
      bvalid_next     = 1'b0;
      wvalue_next     = wvalue;
      bvalue_next     = bvalue;
      layer_tag_next  = layer_tag;
      neuron_tag_next = neuron_tag;

      case (state)
         IDLE: begin
            if (bus.start) begin
               state_next  = WEIGHT;
               layer_next  = 3'd1;
               neuron_next = '0;
               wcnt_next   = '0;
               busy_next   = 1'b1;
            end
         end

         WEIGHT: begin
            if (beat) begin
               wvalid_next     = 1'b1;
               wvalue_next     = bus.s_data;
               layer_tag_next  = 32'(layer);
               neuron_tag_next = 32'(neuron);
               if (wcnt == nw_cur - 1'b1) begin
                  wcnt_next  = '0;
                  state_next = BIAS;
               end else begin
                  wcnt_next = wcnt + 1'b1;
               end
            end
         end

         BIAS: begin
            if (beat) begin
               bvalid_next     = 1'b1;
               bvalue_next     = bus.s_data;
               layer_tag_next  = 32'(layer);
               neuron_tag_next = 32'(neuron);
               if (neuron < nn_cur - 1'b1) begin
                  neuron_next = neuron + 1'b1;
                  state_next  = WEIGHT;
               end else if (layer < 3'd4) begin
                  layer_next  = layer + 3'd1;
                  neuron_next = '0;
                  state_next  = WEIGHT;
               end else begin
                  state_next = DONE;
               end
            end
         end

         DONE: begin
            done_next  = 1'b1;
            busy_next  = 1'b0;
            state_next = IDLE;
         end

         default: begin
            state_next = IDLE;
         end
      endcase

      ready_next = (state_next == WEIGHT) || (state_next == BIAS);
   end

   // State, counters and all outputs; async reset abandons any load in progress.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= IDLE;
         layer      <= '0;
         neuron     <= '0;
         wcnt       <= '0;
         ready      <= 1'b0;
         busy       <= 1'b0;
         done       <= 1'b0;
         wvalid     <= 1'b0;
         bvalid     <= 1'b0;
         wvalue     <= '0;
         bvalue     <= '0;
         layer_tag  <= '0;
         neuron_tag <= '0;
      end else begin
         state      <= state_next;
         layer      <= layer_next;
         neuron     <= neuron_next;
         wcnt       <= wcnt_next;
         ready      <= ready_next;
         busy       <= busy_next;
         done       <= done_next;
         wvalid     <= wvalid_next;
         bvalid     <= bvalid_next;
         wvalue     <= wvalue_next;
         bvalue     <= bvalue_next;
         layer_tag  <= layer_tag_next;
         neuron_tag <= neuron_tag_next;
      end
   end

   assign bus.s_ready           = ready;
   assign bus.busy              = busy;
   assign bus.done              = done;
   assign bus.weightValid       = wvalid;
   assign bus.weightValue       = wvalue;
   assign bus.biasValid         = bvalid;
   assign bus.biasValue         = bvalue;
   assign bus.config_layer_num  = layer_tag;
   assign bus.config_neuron_num = neuron_tag;

endmodule

// File: tb/tb_weight_load_sequencer.sv
// Directed bench for weight_load_sequencer using a small 4-layer geometry
// (NN1=2, NN2..4=1, NW1=3, NW2=2, NW3=1, NW4=1), which gives 15 words per load.
module tb_weight_load_sequencer;

   localparam int DW = 32;
   localparam int NWORDS = 15;

   logic clk = 1'b0;
   logic rst = 1'b1;

   // Free-running 10-unit clock.
   always #5 clk = ~clk;

   weight_load_sequencer_if #(.DATA_WIDTH(DW)) seqBus ();

   weight_load_sequencer #(
      .DATA_WIDTH(DW), .CNT_WIDTH(16),
      .NN1(2), .NN2(1), .NN3(1), .NN4(1),
      .NW1(3), .NW2(2), .NW3(1), .NW4(1)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(seqBus)
   );

   int compared   = 0;
   int mismatched = 0;
   int doneCount  = 0;
   bit bothHigh   = 1'b0;

   // Expected tag sequence for one load, derived by hand from the small geometry.
   int expLayer [NWORDS] = '{1, 1, 1, 1, 1, 1, 1, 1, 2, 2, 2, 3, 3, 4, 4};
   int expNeuron[NWORDS] = '{0, 0, 0, 0, 1, 1, 1, 1, 0, 0, 0, 0, 0, 0, 0};
   bit expBias  [NWORDS] = '{0, 0, 0, 1, 0, 0, 0, 1, 0, 0, 1, 0, 1, 0, 1};

   function automatic logic [31:0] wordVal(input int i);
      return 32'hC0DE_0000 + 32'(i + 1);
   endfunction

   // Counts done pulses and flags any cycle with both strobes high.
   always @(negedge clk) begin
      if (seqBus.done === 1'b1) doneCount++;
      if (seqBus.weightValid === 1'b1 && seqBus.biasValid === 1'b1) bothHigh = 1'b1;
   end

   task automatic test_reset();
      logic [133:0] obs;
      rst = 1'b1;
      seqBus.start = 1'b0;
      seqBus.s_valid = 1'b0;
      seqBus.s_data = '0;
      repeat (2) @(posedge clk);
      #1;
      obs = {seqBus.s_ready, seqBus.busy, seqBus.done, seqBus.weightValid, seqBus.biasValid,
             seqBus.config_layer_num, seqBus.config_neuron_num, seqBus.weightValue, seqBus.biasValue};
      compared++;
      if (obs !== '0) begin
         mismatched++;
         $display("[TB] FAIL reset_outputs got %h want 0", obs);
      end
      rst = 1'b0;
      @(posedge clk); #1;
      compared++;
      if ({seqBus.s_ready, seqBus.busy, seqBus.done} !== 3'b000) begin
         mismatched++;
         $display("[TB] FAIL reset_idle got %b want 000", {seqBus.s_ready, seqBus.busy, seqBus.done});
      end
   endtask

   task automatic test_idle_ignored();
      logic [68:0] obs;
      for (int c = 0; c < 3; c++) begin
         seqBus.s_valid = 1'b1;
         seqBus.s_data = 32'h0000_DEAD;
         @(posedge clk); #1;
         obs = {seqBus.s_ready, seqBus.weightValid, seqBus.biasValid, seqBus.busy, seqBus.done,
                seqBus.weightValue, seqBus.biasValue};
         compared++;
         if (obs !== '0) begin
            mismatched++;
            $display("[TB] FAIL idle_ignored cycle %0d got %h want 0", c, obs);
         end
      end
      seqBus.s_valid = 1'b0;
   endtask

   task automatic test_full_load(input int startPulseAt, input string name);
      logic [97:0] obs, exp;
      int doneBefore = doneCount;
      seqBus.start = 1'b1;
      @(posedge clk); #1;
      seqBus.start = 1'b0;
      compared++;
      if ({seqBus.s_ready, seqBus.busy, seqBus.weightValid, seqBus.biasValid} !== 4'b1100) begin
         mismatched++;
         $display("[TB] FAIL %s_started got %b want 1100", name,
                  {seqBus.s_ready, seqBus.busy, seqBus.weightValid, seqBus.biasValid});
      end
      for (int i = 0; i < NWORDS; i++) begin
         seqBus.s_valid = 1'b1;
         seqBus.s_data = wordVal(i);
         seqBus.start = (i == startPulseAt);
         @(posedge clk); #1;
         seqBus.start = 1'b0;
         obs = {seqBus.weightValid, seqBus.biasValid, seqBus.config_layer_num, seqBus.config_neuron_num,
                expBias[i] ? seqBus.biasValue : seqBus.weightValue};
         exp = {~expBias[i], expBias[i], 32'(expLayer[i]), 32'(expNeuron[i]), wordVal(i)};
         compared++;
         if (obs !== exp) begin
            mismatched++;
            $display("[TB] FAIL %s_word%0d got %h want %h", name, i + 1, obs, exp);
         end
      end
      @(posedge clk); #1;
      compared++;
      if ({seqBus.done, seqBus.busy, seqBus.weightValid, seqBus.biasValid, seqBus.s_ready} !== 5'b10000) begin
         mismatched++;
         $display("[TB] FAIL %s_done got %b want 10000", name,
                  {seqBus.done, seqBus.busy, seqBus.weightValid, seqBus.biasValid, seqBus.s_ready});
      end
      seqBus.s_valid = 1'b0;
      @(posedge clk); #1;
      compared++;
      if ({seqBus.done, seqBus.busy, seqBus.weightValid, seqBus.biasValid, seqBus.s_ready} !== 5'b00000) begin
         mismatched++;
         $display("[TB] FAIL %s_after_done got %b want 00000", name,
                  {seqBus.done, seqBus.busy, seqBus.weightValid, seqBus.biasValid, seqBus.s_ready});
      end
      compared++;
      if (doneCount - doneBefore !== 1) begin
         mismatched++;
         $display("[TB] FAIL %s_done_count got %0d want 1", name, doneCount - doneBefore);
      end
   endtask

   task automatic test_gapped_stream();
      logic [97:0] obs, exp;
      int doneBefore = doneCount;
      seqBus.start = 1'b1;
      @(posedge clk); #1;
      seqBus.start = 1'b0;
      for (int i = 0; i < NWORDS; i++) begin
         seqBus.s_valid = 1'b1;
         seqBus.s_data = wordVal(i);
         @(posedge clk); #1;
         obs = {seqBus.weightValid, seqBus.biasValid, seqBus.config_layer_num, seqBus.config_neuron_num,
                expBias[i] ? seqBus.biasValue : seqBus.weightValue};
         exp = {~expBias[i], expBias[i], 32'(expLayer[i]), 32'(expNeuron[i]), wordVal(i)};
         compared++;
         if (obs !== exp) begin
            mismatched++;
            $display("[TB] FAIL gapped_word%0d got %h want %h", i + 1, obs, exp);
         end
         seqBus.s_valid = 1'b0;
         seqBus.s_data = 32'h0000_DEAD;
         if (i < NWORDS - 1) begin
            @(posedge clk); #1;
            compared++;
            if ({seqBus.weightValid, seqBus.biasValid} !== 2'b00) begin
               mismatched++;
               $display("[TB] FAIL gapped_gap%0d got %b want 00", i + 1,
                        {seqBus.weightValid, seqBus.biasValid});
            end
         end
      end
      @(posedge clk); #1;
      compared++;
      if ({seqBus.done, seqBus.busy} !== 2'b10) begin
         mismatched++;
         $display("[TB] FAIL gapped_done got %b want 10", {seqBus.done, seqBus.busy});
      end
      @(posedge clk); #1;
      compared++;
      if (doneCount - doneBefore !== 1) begin
         mismatched++;
         $display("[TB] FAIL gapped_done_count got %0d want 1", doneCount - doneBefore);
      end
   endtask

   task automatic test_mid_load_reset();
      logic [134:0] obs;
      int doneBefore = doneCount;
      seqBus.start = 1'b1;
      @(posedge clk); #1;
      seqBus.start = 1'b0;
      for (int i = 0; i < 6; i++) begin
         seqBus.s_valid = 1'b1;
         seqBus.s_data = wordVal(i);
         @(posedge clk); #1;
      end
      rst = 1'b1;
      #1;
      obs = {seqBus.s_ready, seqBus.busy, seqBus.done, seqBus.weightValid, seqBus.biasValid,
             seqBus.config_layer_num, seqBus.config_neuron_num, seqBus.weightValue, seqBus.biasValue, 1'b0};
      compared++;
      if (obs !== '0) begin
         mismatched++;
         $display("[TB] FAIL midreset_outputs got %h want 0", obs);
      end
      seqBus.s_valid = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      compared++;
      if ({doneCount - doneBefore, seqBus.busy, seqBus.s_ready} !== {32'd0, 2'b00}) begin
         mismatched++;
         $display("[TB] FAIL midreset_quiet got done_count %0d busy %b ready %b want 0 0 0",
                  doneCount - doneBefore, seqBus.busy, seqBus.s_ready);
      end
   endtask

   task automatic test_exclusive_strobes();
      compared++;
      if (bothHigh !== 1'b0) begin
         mismatched++;
         $display("[TB] FAIL exclusive_strobes got %b want 0", bothHigh);
      end
   endtask

   // Scenario sequence; each task leaves the sequencer idle for the next.
   initial begin
      test_reset();
      test_idle_ignored();
      test_full_load(-1, "full");
      test_gapped_stream();
      test_full_load(4, "start_busy");
      test_mid_load_reset();
      test_full_load(-1, "after_reset");
      test_exclusive_strobes();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
